bch_ibm_seq: RTL
================

// Module: bch_ibm_seq
// PURPOSE
//  Iterative, parametrised inversionless Berlekamp-Massey solver for binary BCH over GF(2^M).
//  Performs one simplified-BM iteration per clock, taking T cycles to produce the error-locator
//  polynomial. The locator is scaled, with no field inversion. Sits between the syndrome
//  generator and the Chien search. Valid/ready on both sides. Flags decoder failure.
// PARAMETERS
//  M          4        field degree; GF(2^M) symbols are M bits
//  T          2        correction capability; T iterations, locator degree <= T
//  PRIM_POLY  5'h13    primitive polynomial, M+1 bits (default x^4+x+1)
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          syndrome vector valid
//  in_ready   out  1          block can accept a syndrome vector
//  syndrome   in   (2T-1)*M   S_j at [(j-1)*M +: M], j=1..2T-1
//  out_valid  out  1          result valid
//  out_ready  in   1          downstream accepts result
//  locator    out  (T+1)*M    nu_i at [i*M +: M], i=0..T (scaled locator)
//  err_cnt    out  LW         final L; LW=$clog2(2T)>0?$clog2(2T):1
//  err_fail   out  1          uncorrectable (L>T or deg(nu)!=L)
// BEHAVIOUR
//  - One clock domain. Reset is synchronous and active-high.
//  - Reset values: in_ready=0, out_valid=0, locator=0, err_cnt=0, err_fail=0, FSM=IDLE.
//    in_ready is 1 from the cycle after rst deasserts.
//  - GF multiply: polynomial product reduced by PRIM_POLY. Addition is XOR.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid, register the syndromes and initialise:
//    nu=1, kappa=1, delta=1, L=0, r=0.
//    If every syndrome is 0, go to DONE with locator=1, err_cnt=0, err_fail=0
//    (zero bypass, 1-cycle latency). Otherwise go to RUN.
//  - RUN, one iteration per cycle for r=0..T-1:
//    d = XOR over i=0..min(2r,T) of nu_i*S_(2r+1-i).
//    nu' = delta*nu + d*x*kappa, truncated to coefficients 0..T.
//    If d==0 or L>r: kappa' = x^2*kappa (truncated to 0..T); delta and L unchanged.
//    Else: kappa' = x*nu (old nu, truncated); delta' = d; L' = 2r+1-L.
//    After iteration r=T-1, go to DONE. Latency from accept to out_valid is T cycles.
//  - DONE: out_valid=1. locator, err_cnt and err_fail are stable until out_ready.
//    On out_valid&&out_ready, go to IDLE; out_valid drops the next cycle.
//  - err_fail = (L>T) | (highest nonzero index of nu != L). Evaluated in DONE.
//  - in_ready=0 in RUN and DONE; in_valid is ignored there. No input buffering.
//  - rst in any state: immediate return to IDLE with reset values. The in-flight result is discarded.
//  - Coefficients truncated beyond x^T are discarded silently; err_fail exposes the effect.
// TESTING (M=4, T=2, alpha=0010, x^4+x+1)
//  1 zero: S1=S2=S3=0 -> out_valid 1 cycle after accept; locator=[0001,0000,0000], err_cnt=0, err_fail=0
//  2 single error at pos 3: S1=1000,S2=1100,S3=1010 -> after 2 cycles locator=[1000,1100,0000],
//    err_cnt=1, err_fail=0
//  3 errors at pos 0,1: S1=0011,S2=0101,S3=1001 -> locator=[0011,0101,0110], err_cnt=2, err_fail=0
//  4 uncorrectable: S1=0,S2=0,S3=0001 -> locator=[0001,0000,0000], err_cnt=3, err_fail=1
//  5 backpressure: out_ready=0 for 5 cycles in DONE -> outputs held, in_ready=0;
//    a new in_valid is not accepted until the cycle after the out handshake
//  6 rst asserted mid-RUN (after iteration 0) -> next cycle IDLE, out_valid=0;
//    next vector from test 3 yields the test 3 result

Source files
------------

// File: rtl/bch_ibm_seq.sv
// bch_ibm_seq: iterative inversionless Berlekamp-Massey solver for binary BCH over GF(2^M)
module bch_ibm_seq #(
  parameter int M = 4,
  parameter int T = 2,
  parameter logic [M:0] PRIM_POLY = 5'h13,
  localparam int LW = $clog2(2*T) > 0 ? $clog2(2*T) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [(2*T-1)*M-1:0] syndrome,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [(T+1)*M-1:0]   locator,
  output logic [LW-1:0]        err_cnt,
  output logic                 err_fail
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [M-1:0] syn_q [2*T-1];
  logic [M-1:0] syn_s [2*T-1];
  logic [M-1:0] nu_q [T+1];
  logic [M-1:0] nu_s [T+1];
  logic [M-1:0] nu_n [T+1];
  logic [M-1:0] kappa_q [T+1];
  logic [M-1:0] kappa_s [T+1];
  logic [M-1:0] kappa_n [T+1];
  logic [M-1:0] delta_q, delta_s, delta_n, d;
  logic [LW-1:0] l_q, l_s, l_n, r_q;
  logic rdy_q, acc, zero, upd, idle;
  int r_s, deg;

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p, s;
    p = '0;
    s = a;
    for (int i = 0; i < M; i++) begin
      p = b[i] ? p ^ s : p;
      s = s[M-1] ? (s << 1) ^ PRIM_POLY[M-1:0] : s << 1;
    end
    return p;
  endfunction

  // One BM iteration; in IDLE it runs iteration 0 from the initial values on the incoming vector
  always_comb begin
    idle = (state == IDLE);
    acc = in_valid && rdy_q;
    zero = (syndrome == '0);
    for (int j = 0; j < 2*T-1; j++) syn_s[j] = idle ? syndrome[j*M +: M] : syn_q[j];
    for (int i = 0; i <= T; i++) begin
      nu_s[i] = idle ? M'(i == 0) : nu_q[i];
      kappa_s[i] = idle ? M'(i == 0) : kappa_q[i];
    end
    delta_s = idle ? M'(1) : delta_q;
    l_s = idle ? '0 : l_q;
    r_s = idle ? 0 : int'(r_q);
    d = '0;
    for (int i = 0; i <= T; i++) if (i <= 2*r_s) d ^= gf_mul(nu_s[i], syn_s[2*r_s-i]);
    upd = (d != '0) && (int'(l_s) <= r_s);
    for (int i = 0; i <= T; i++) begin
      nu_n[i] = gf_mul(delta_s, nu_s[i]);
      kappa_n[i] = '0;
      if (i > 0) begin
        nu_n[i] ^= gf_mul(d, kappa_s[i-1]);
        if (upd) kappa_n[i] = nu_s[i-1];
      end
      if (!upd && i > 1) kappa_n[i] = kappa_s[i-2];
    end
    delta_n = upd ? d : delta_s;
    l_n = upd ? LW'(2*r_s + 1 - int'(l_s)) : l_s;
  end

  // Next state; an all-zero vector skips the iterations entirely
  always_comb begin
    state_n = state;
    state_n = idle ? (acc ? ((zero || T == 1) ? DONE : RUN) : IDLE)
            : (state == RUN) ? (r_q == LW'(T-1) ? DONE : RUN)
            : (out_ready ? IDLE : DONE);
  end

  // Failure when L exceeds T or the locator degree disagrees with L
  always_comb begin
    deg = -1;
    for (int i = 0; i <= T; i++) if (nu_q[i] != '0) deg = i;
    err_fail = (state == DONE) && (int'(l_q) > T || deg != int'(l_q));
    for (int i = 0; i <= T; i++) locator[i*M +: M] = nu_q[i];
  end

  assign in_ready = rdy_q;
  assign out_valid = (state == DONE);
  assign err_cnt = l_q;

  // State register; ready is registered so it rises the cycle after reset releases
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rdy_q <= 1'b0;
    end else begin
      state <= state_n;
      rdy_q <= (state_n == IDLE);
    end
  end

  // Iteration registers: loaded with iteration 0 on accept, then one iteration per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= T; i++) begin
        nu_q[i] <= '0;
        kappa_q[i] <= '0;
      end
      for (int j = 0; j < 2*T-1; j++) syn_q[j] <= '0;
      delta_q <= '0;
      l_q <= '0;
      r_q <= '0;
    end else if (acc || state == RUN) begin
      for (int i = 0; i <= T; i++) begin
        nu_q[i] <= nu_n[i];
        kappa_q[i] <= kappa_n[i];
      end
      if (acc) for (int j = 0; j < 2*T-1; j++) syn_q[j] <= syn_s[j];
      delta_q <= delta_n;
      l_q <= l_n;
      r_q <= acc ? LW'(1) : r_q + 1'b1;
    end
  end
endmodule
